multicycle_ctrl: RTL

//  Multicycle MIPS control FSM. Replaces the single-cycle main decoder when the core

---
 rtl/multicycle_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore decode of state drives datapath muxes and write enables.
// Latency (mem_ready=1): lw 5, sw 4, rtype/addi 4, beq/j 3 cycles; FETCH/MEMRD/MEMWR hold while mem_ready=0.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsrc,
    output logic             pcen,
    output logic [3:0]       state_o,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_RTEX   = 4'd6;
    localparam logic [3:0] S_RTWB   = 4'd7;
    localparam logic [3:0] S_BEQEX  = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JEX    = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pcwrite, branch, retire;
    logic             irwrite_raw, memwrite_raw, regwrite_raw, illegal_raw;

    always_comb begin
        state_d      = state_q;
        iord         = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        regwrite_raw = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        aluop        = 2'b00;
        pcsrc        = 2'b00;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        illegal_raw  = 1'b0;
        retire       = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC+4 and IR load only commit on the cycle memory delivers the word
                alusrcb     = 2'b01;
                irwrite_raw = mem_ready;
                pcwrite     = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        state_d     = S_FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
                retire       = 1'b1;
            end
            S_RTEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = S_RTWB;
            end
            S_RTWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
                retire       = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
                retire       = 1'b1;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes are gated by rst_n so nothing writes while reset is held, even in FETCH.
    assign irwrite    = irwrite_raw & rst_n;
    assign memwrite   = memwrite_raw & rst_n;
    assign regwrite   = regwrite_raw & rst_n;
    assign illegal_op = illegal_raw & rst_n;
    assign pcen       = (pcwrite | (branch & zero)) & rst_n;
    assign state_o    = state_q;
    assign instr_cnt  = cnt_q;

endmodule
